data_sram_bridge: RTL and testbench

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 155 +++++++++++++++
 tb/tb_data_sram_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle data SRAM port onto a split address/data handshake bus.
// The pipeline is stalled while an access is outstanding. A sticky bus_err flags accesses that wait too long.
module data_sram_bridge #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] LIMIT_C = WAIT_LIMIT[7:0];

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // Full-word and irregular strobe patterns both travel as a word access.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b0000, 4'b1111:                   sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Next-state, latched request fields, read capture and wait counter.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (data_sram_en) begin
                    state_d = S_REQ;
                    wr_d    = (data_sram_wen != 4'b0000);
                    size_d  = size_of(data_sram_wen);
                    addr_d  = data_sram_addr;
                    wdata_d = data_sram_wdata;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = sat_inc(cnt_q);
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        state_d = S_DONE;
                        if (!wr_q) begin
                            rdata_d = bus_rdata;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                cnt_d = sat_inc(cnt_q);
                if (bus_data_ok) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            // The EX stage still shows the finished instruction here, so en is ignored.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ);
        err_d = err_q | (((state_q == S_REQ) || (state_q == S_RESP)) && (cnt_d == LIMIT_C));
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign stallreq        = ((state_q == S_IDLE) && data_sram_en) ||
                             (state_q == S_REQ) || (state_q == S_RESP);
    assign bus_req         = req_q;
    assign bus_wr          = wr_q;
    assign bus_size        = size_q;
    assign bus_addr        = addr_q;
    assign bus_wdata       = wdata_q;
    assign data_sram_rdata = rdata_q;
    assign bus_err         = err_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: reads, stores, combined strobes, stalled bus, timeout and reset.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int hs     = 0;
    int hs0    = 0;

    data_sram_bridge #(.WAIT_LIMIT(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stallreq       (stallreq),
        .bus_req        (bus_req),
        .bus_wr         (bus_wr),
        .bus_size       (bus_size),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_addr_ok    (bus_addr_ok),
        .bus_data_ok    (bus_data_ok),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    // Count accepted address handshakes.
    always @(posedge clk) begin
        if (resetn && bus_req && bus_addr_ok) hs <= hs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'd0;
        data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        #12;
        chk("rst_req",   32'(bus_req),  32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        data_sram_en = 1'b1; #1;
        chk("rst_stall_en", 32'(stallreq), 32'd1);
        data_sram_en = 1'b0; #1;
        chk("rst_addr",  bus_addr,        32'd0);
        chk("rst_rdata", data_sram_rdata, 32'd0);
        chk("rst_err",   32'(bus_err),    32'd0);
        #10; resetn = 1'b1;
        step();

        // Read of 0x1000, addr_ok on first REQ cycle, data one cycle later.
        hs0 = hs;
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_1000; #1;
        chk("rd_stall_idle", 32'(stallreq), 32'd1);
        step();
        chk("rd_req",   32'(bus_req),  32'd1);
        chk("rd_size",  32'(bus_size), 32'd2);
        chk("rd_wr",    32'(bus_wr),   32'd0);
        chk("rd_addr",  bus_addr,      32'h0000_1000);
        chk("rd_stall_req", 32'(stallreq), 32'd1);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_req_resp",   32'(bus_req),  32'd0);
        chk("rd_stall_resp", 32'(stallreq), 32'd1);
        step();
        bus_data_ok = 1'b0; bus_rdata = 32'd0; #1;
        chk("rd_stall_done", 32'(stallreq), 32'd0);
        chk("rd_rdata",      data_sram_rdata, 32'hDEAD_BEEF);
        step();
        data_sram_en = 1'b0; #1;
        chk("rd_req_after", 32'(bus_req), 32'd0);
        chk("rd_hs",        32'(hs - hs0), 32'd1);

        // Spurious data_ok in IDLE.
        bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
        step();
        bus_data_ok = 1'b0; #1;
        chk("spur_req",   32'(bus_req),  32'd0);
        chk("spur_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        chk("spur_stall", 32'(stallreq), 32'd0);

        // Byte store.
        data_sram_en = 1'b1; data_sram_wen = 4'b0100;
        data_sram_addr = 32'h0000_2002; data_sram_wdata = 32'h00AB_0000;
        step();
        chk("bs_wr",    32'(bus_wr),   32'd1);
        chk("bs_size",  32'(bus_size), 32'd0);
        chk("bs_addr",  bus_addr,      32'h0000_2002);
        chk("bs_wdata", bus_wdata,     32'h00AB_0000);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_data_ok = 1'b0; #1;
        chk("bs_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        step();
        data_sram_en = 1'b0;

        // Combined addr_ok/data_ok in first REQ cycle.
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_3000;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("cmb_stall", 32'(stallreq), 32'd0);
        chk("cmb_req",   32'(bus_req),  32'd0);
        chk("cmb_rdata", data_sram_rdata, 32'h1234_5678);

        // Back-to-back: word write presented on the cycle after DONE.
        step();
        data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_4000; data_sram_wdata = 32'hCAFE_F00D; #1;
        chk("b2b_stall", 32'(stallreq), 32'd1);
        step();
        chk("b2b_req",   32'(bus_req),  32'd1);
        chk("b2b_wr",    32'(bus_wr),   32'd1);
        chk("b2b_size",  32'(bus_size), 32'd2);
        chk("b2b_addr",  bus_addr,      32'h0000_4000);
        chk("b2b_wdata", bus_wdata,     32'hCAFE_F00D);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        step();
        bus_data_ok = 1'b0;
        chk("b2b_rdata", data_sram_rdata, 32'h1234_5678);
        step();
        data_sram_en = 1'b0;

        // Stalled bus: addr_ok withheld for 5 REQ cycles, half-word store.
        hs0 = hs;
        data_sram_en = 1'b1; data_sram_wen = 4'b1100;
        data_sram_addr = 32'h0000_5004; data_sram_wdata = 32'h1122_3344;
        step();
        chk("stl_size", 32'(bus_size), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stl_req",   32'(bus_req),  32'd1);
            chk("stl_addr",  bus_addr,      32'h0000_5004);
            chk("stl_wdata", bus_wdata,     32'h1122_3344);
            step();
        end
        chk("stl_err",      32'(bus_err), 32'd1);
        chk("stl_req_held", 32'(bus_req), 32'd1);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        step();
        bus_data_ok = 1'b0;
        step();
        chk("stl_no_reissue", 32'(bus_req), 32'd0);
        data_sram_en = 1'b0;
        step();
        chk("stl_idle_req", 32'(bus_req), 32'd0);
        chk("stl_hs",       32'(hs - hs0), 32'd1);

        // Reset clears sticky error.
        resetn = 1'b0; #1;
        chk("rst2_err", 32'(bus_err), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Timeout: data_ok never arrives.
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_6000;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        step();
        step();
        chk("to_err_3", 32'(bus_err), 32'd0);
        step();
        chk("to_err_4", 32'(bus_err),  32'd1);
        chk("to_stall", 32'(stallreq), 32'd1);
        step();
        chk("to_stall_hold", 32'(stallreq), 32'd1);
        resetn = 1'b0; data_sram_en = 1'b0; #1;
        chk("to_rst_err",   32'(bus_err),  32'd0);
        chk("to_rst_req",   32'(bus_req),  32'd0);
        chk("to_rst_stall", 32'(stallreq), 32'd0);
        chk("to_rst_rdata", data_sram_rdata, 32'd0);
        step();
        resetn = 1'b1;
        bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777;
        step();
        bus_data_ok = 1'b0;
        step();
        chk("post_rst_req",   32'(bus_req),  32'd0);
        chk("post_rst_rdata", data_sram_rdata, 32'd0);
        chk("post_rst_stall", 32'(stallreq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
